// File: rtl/i_cache_refill.sv
// i_cache_refill: miss-refill engine feeding the instruction cache fill port.
// Fetches a missing line as LINE_SIZE beats and strobes it into the cache.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module i_cache_refill #(
    parameter int LINE_SIZE  = 2,
    parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                miss,
    input  logic [ADDR_WIDTH-1:0]     miss_addr [2],
    input  logic                      ext_stall,
    input  logic                      ext_flush,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_WIDTH-1:0]     mem_req_addr,
    input  logic                      mem_resp_valid,
    input  logic [31:0]               mem_resp_data,
    output logic [ADDR_WIDTH-1:0]     fetch_addr,
    output logic                      fetch_addr_valid,
    output logic [32*LINE_SIZE-1:0]   fetched_data,
    output logic                      refill_busy
);

    localparam int CW = $clog2(LINE_SIZE);
    localparam int DW = 32 * LINE_SIZE;
    localparam logic [ADDR_WIDTH-1:0] OFF = ADDR_WIDTH'(4 * LINE_SIZE - 1);
    localparam logic [CW-1:0] LAST = CW'(LINE_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        COLLECT,
        WRITE,
        DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] line_q, line_d;
    logic [ADDR_WIDTH-1:0] pend_q, pend_d;
    logic                  pend_v_q, pend_v_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DW-1:0]         line_buf_q;
    logic                  beat_we;
    logic                  fill;
    logic [ADDR_WIDTH-1:0] line0, line1;

    assign line0 = miss_addr[0] & ~OFF;
    assign line1 = miss_addr[1] & ~OFF;

    assign refill_busy      = (state_q != IDLE);
    assign mem_req_valid    = (state_q == REQ);
    assign mem_req_addr     = mem_req_valid ? line_q : '0;
    assign fetch_addr       = (state_q == WRITE) ? line_q : '0;
    assign fetched_data     = (state_q == WRITE) ? line_buf_q : '0;
    assign fetch_addr_valid = fill;

    // State, line address, pending slot and beat counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            line_q   <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            cnt_q    <= cnt_d;
        end
    end

    // Line assembly buffer: each accepted beat lands in word beat_cnt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_buf_q <= '0;
        end else if (beat_we) begin
            line_buf_q[32*cnt_q +: 32] <= mem_resp_data;
        end
    end

    // Next-state logic; flush wins over every other event.
    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        cnt_d    = cnt_q;
        beat_we  = 1'b0;
        fill     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!ext_flush && |miss) begin
                    state_d = REQ;
                    if (miss[0]) begin
                        line_d = line0;
                        if (miss[1] && line1 != line0) begin
                            pend_d   = line1;
                            pend_v_d = 1'b1;
                        end
                    end else begin
                        line_d = line1;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = ext_flush ? DRAIN : COLLECT;
                end else if (ext_flush) begin
                    state_d = IDLE;
                end
            end
            COLLECT: begin
                if (mem_resp_valid) begin
                    beat_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
                if (mem_resp_valid && cnt_q == LAST) begin
                    state_d = ext_flush ? IDLE : WRITE;
                end else if (ext_flush) begin
                    state_d = DRAIN;
                end
            end
            WRITE: begin
                if (ext_flush) begin
                    state_d = IDLE;
                end else if (!ext_stall) begin
                    fill = 1'b1;
                    if (pend_v_q) begin
                        line_d   = pend_q;
                        pend_d   = '0;
                        pend_v_d = 1'b0;
                        state_d  = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (mem_resp_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (ext_flush) begin
            pend_d   = '0;
            pend_v_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_i_cache_refill.sv
// tb_i_cache_refill: randomized scoreboard bench for the i-cache refill engine.
// A memory responder serves requests; a monitor checks requests and fills.
module tb_i_cache_refill;

    localparam int LS = 2;
    localparam int AW = 32;
    localparam int DW = 32 * LS;
    localparam logic [31:0] OFF = 32'(4 * LS - 1);

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } fill_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    miss;
    logic [AW-1:0] miss_addr [2];
    logic          ext_stall;
    logic          ext_flush;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic [AW-1:0] mem_req_addr;
    logic          mem_resp_valid = 1'b0;
    logic [31:0]   mem_resp_data = '0;
    logic [AW-1:0] fetch_addr;
    logic          fetch_addr_valid;
    logic [DW-1:0] fetched_data;
    logic          refill_busy;

    i_cache_refill #(.LINE_SIZE(LS), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .reset(reset),
        .miss(miss),
        .miss_addr(miss_addr),
        .ext_stall(ext_stall),
        .ext_flush(ext_flush),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data),
        .fetch_addr(fetch_addr),
        .fetch_addr_valid(fetch_addr_valid),
        .fetched_data(fetched_data),
        .refill_busy(refill_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err = 0;
    logic [31:0] salt;

    logic [AW-1:0] exp_req [$];
    fill_t         exp_fill [$];

    int n_fill = 0;
    int last_fill_cyc = 0;
    int miss_cyc = 0;

    bit          resp_busy = 0;
    logic [31:0] resp_line = '0;
    int          resp_idx = 0;
    int          gap_cnt = 0;
    int          beat_gap = 0;
    int          rdy_low = 0;
    bit          rand_gap = 0;
    bit          rand_rdy = 0;
    bit          inject_stray = 0;
    int          mem_sent = 0;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] line, input int i);
        logic [7:0] ib;
        ib = i[7:0];
        if (line == 32'h1000) begin
            return (i == 0) ? 32'hAAAA0001 : 32'hBBBB0002;
        end
        return {line[15:0], ib, 8'h5A} ^ salt;
    endfunction

    // Reference model: the distinct lines a miss pattern must fetch, in order.
    task automatic model_push(input logic [1:0] m, input logic [31:0] a0,
                              input logic [31:0] a1, input bit req_en,
                              input bit fill_en);
        logic [31:0] l [$];
        logic [31:0] l1;
        fill_t f;
        if (m[0]) l.push_back(a0 & ~OFF);
        if (m[1]) begin
            l1 = a1 & ~OFF;
            if (!(m[0] && l1 == l[0])) l.push_back(l1);
        end
        foreach (l[k]) begin
            if (req_en) exp_req.push_back(l[k]);
            if (fill_en) begin
                f.a = l[k];
                for (int w = 0; w < LS; w++) f.d[32*w +: 32] = mem_word(l[k], w);
                exp_fill.push_back(f);
            end
        end
    endtask

    task automatic issue(input logic [1:0] m, input logic [31:0] a0,
                         input logic [31:0] a1, input bit req_en,
                         input bit fill_en);
        model_push(m, a0, a1, req_en, fill_en);
        @(posedge clk); #1;
        miss = m;
        miss_addr[0] = a0;
        miss_addr[1] = a1;
        miss_cyc = cyc;
        @(posedge clk); #1;
        miss = 2'b00;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        do begin
            @(posedge clk); #1;
            i++;
        end while (refill_busy && i < 500);
        if (refill_busy) check(1'b0, {"idle_timeout_", tag}, 1, 0);
    endtask

    task automatic wait_beats(input int target, input string tag);
        int i;
        for (i = 0; i < 200; i++) begin
            @(posedge clk);
            if (mem_sent >= target) break;
        end
        if (mem_sent < target) check(1'b0, {"beat_timeout_", tag}, mem_sent, target);
    endtask

    task automatic queues_empty(input string tag);
        check(exp_req.size() == 0, {"req_left_", tag}, exp_req.size(), 0);
        check(exp_fill.size() == 0, {"fill_left_", tag}, exp_fill.size(), 0);
    endtask

    // Memory model: accepts one request, returns LS beats with optional gaps.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                resp_busy = 0;
            end else begin
                if (mem_resp_valid && resp_busy) begin
                    resp_idx++;
                    mem_sent++;
                    if (resp_idx == LS) resp_busy = 0;
                end
                if (mem_req_valid && mem_req_ready) begin
                    resp_busy = 1;
                    resp_line = mem_req_addr;
                    resp_idx = 0;
                    gap_cnt = rand_gap ? int'($urandom % 3) : beat_gap;
                end
                if (mem_req_valid && !mem_req_ready && rdy_low > 0) rdy_low--;
            end
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
            if (inject_stray) begin
                mem_resp_valid = 1'b1;
                mem_resp_data = $urandom;
                inject_stray = 0;
            end else if (resp_busy && !reset) begin
                if (gap_cnt > 0) begin
                    gap_cnt--;
                end else begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data = mem_word(resp_line, resp_idx);
                    gap_cnt = rand_gap ? int'($urandom % 3) : beat_gap;
                end
            end
            if (rdy_low > 0) mem_req_ready = 1'b0;
            else if (rand_rdy) mem_req_ready = ($urandom % 2 == 0);
            else mem_req_ready = 1'b1;
        end
    end

    // Monitor: checks each request handshake and fill strobe against the queues.
    initial begin
        bit prev_wait;
        bit prev_fill;
        logic [AW-1:0] prev_addr;
        logic [AW-1:0] ra;
        fill_t f;
        prev_wait = 0;
        prev_fill = 0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_wait = 0;
                prev_fill = 0;
            end else begin
                if (mem_req_valid) begin
                    if (prev_wait) check(mem_req_addr == prev_addr, "req_hold", mem_req_addr, prev_addr);
                    if (mem_req_ready) begin
                        prev_wait = 0;
                        if (exp_req.size() == 0) begin
                            check(1'b0, "req_unexpected", mem_req_addr, 0);
                        end else begin
                            ra = exp_req.pop_front();
                            check(mem_req_addr == ra, "req_addr", mem_req_addr, ra);
                        end
                    end else begin
                        prev_wait = 1;
                        prev_addr = mem_req_addr;
                    end
                end else begin
                    prev_wait = 0;
                end
                if (fetch_addr_valid) begin
                    n_fill++;
                    last_fill_cyc = cyc;
                    check(!prev_fill, "strobe_width", 1, 0);
                    check(!ext_stall, "strobe_in_stall", ext_stall, 0);
                    if (exp_fill.size() == 0) begin
                        check(1'b0, "fill_unexpected", fetch_addr, 0);
                    end else begin
                        f = exp_fill.pop_front();
                        check(fetch_addr == f.a, "fill_addr", fetch_addr, f.a);
                        check(fetched_data == f.d, "fill_data", fetched_data, f.d);
                    end
                end
                prev_fill = fetch_addr_valid;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int nf0;
        logic [1:0] m;
        logic [31:0] a0, a1;
        fill_t f;

        salt = $urandom;
        miss = 2'b00;
        miss_addr[0] = '0;
        miss_addr[1] = '0;
        ext_stall = 1'b0;
        ext_flush = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check(refill_busy == 0, "rst_busy", refill_busy, 0);
        check(mem_req_valid == 0, "rst_req_valid", mem_req_valid, 0);
        check(fetch_addr_valid == 0, "rst_fill_valid", fetch_addr_valid, 0);
        check(fetched_data == 0, "rst_data", fetched_data, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single miss, fixed beats, minimal latency.
        beat_gap = 0;
        nf0 = n_fill;
        exp_req.push_back(32'h1000);
        f.a = 32'h1000;
        f.d = 64'hBBBB0002_AAAA0001;
        exp_fill.push_back(f);
        issue(2'b01, 32'h1004, 32'h0, 0, 0);
        wait_idle("t1");
        check(last_fill_cyc - miss_cyc == LS + 2, "fill_latency", last_fill_cyc - miss_cyc, LS + 2);
        check(n_fill - nf0 == 1, "t1_fills", n_fill - nf0, 1);
        queues_empty("t1");

        // Dual miss, different lines.
        nf0 = n_fill;
        issue(2'b11, 32'h2000, 32'h3008, 1, 1);
        wait_idle("t2");
        check(n_fill - nf0 == 2, "t2_fills", n_fill - nf0, 2);
        queues_empty("t2");

        // Dual miss, same line.
        nf0 = n_fill;
        issue(2'b11, 32'h2000, 32'h2004, 1, 1);
        wait_idle("t3");
        check(n_fill - nf0 == 1, "t3_fills", n_fill - nf0, 1);
        queues_empty("t3");

        // Backpressure on the request, then stall held in WRITE.
        nf0 = n_fill;
        rdy_low = 5;
        ext_stall = 1'b1;
        s0 = mem_sent;
        issue(2'b01, 32'h700C, 32'h0, 1, 1);
        wait_beats(s0 + LS, "t4");
        @(negedge clk);
        check(refill_busy == 1, "t4_busy_stall", refill_busy, 1);
        check(fetch_addr_valid == 0, "t4_no_strobe", fetch_addr_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        ext_stall = 1'b0;
        wait_idle("t4");
        check(n_fill - nf0 == 1, "t4_fills", n_fill - nf0, 1);
        queues_empty("t4");

        // Flush after beat 0: beat 1 drained, no fill.
        nf0 = n_fill;
        beat_gap = 3;
        s0 = mem_sent;
        issue(2'b01, 32'h5010, 32'h0, 1, 0);
        wait_beats(s0 + 1, "t5");
        #1;
        ext_flush = 1'b1;
        @(posedge clk); #1;
        ext_flush = 1'b0;
        @(negedge clk);
        check(refill_busy == 1, "t5_drain_busy", refill_busy, 1);
        wait_beats(s0 + LS, "t5b");
        @(negedge clk);
        check(refill_busy == 0, "t5_idle", refill_busy, 0);
        check(n_fill == nf0, "t5_no_fill", n_fill - nf0, 0);
        beat_gap = 0;
        issue(2'b10, 32'h0, 32'h5020, 1, 1);
        wait_idle("t5c");
        check(n_fill - nf0 == 1, "t5_next_fill", n_fill - nf0, 1);
        queues_empty("t5");

        // Flush while the request is backpressured.
        nf0 = n_fill;
        rdy_low = 3;
        issue(2'b01, 32'h8000, 32'h0, 0, 0);
        ext_flush = 1'b1;
        @(posedge clk); #1;
        ext_flush = 1'b0;
        @(negedge clk);
        check(refill_busy == 0, "req_flush_idle", refill_busy, 0);
        check(mem_req_valid == 0, "req_flush_valid", mem_req_valid, 0);
        @(posedge clk); #1;
        rdy_low = 0;
        repeat (4) @(posedge clk);
        check(n_fill == nf0, "req_flush_no_fill", n_fill - nf0, 0);
        queues_empty("rf");

        // Asynchronous reset while collecting.
        nf0 = n_fill;
        beat_gap = 3;
        s0 = mem_sent;
        issue(2'b01, 32'h6000, 32'h0, 1, 0);
        wait_beats(s0 + 1, "t6");
        #3;
        reset = 1'b1;
        #1;
        check(refill_busy == 0, "t6_busy", refill_busy, 0);
        check(mem_req_valid == 0, "t6_req_valid", mem_req_valid, 0);
        check(fetch_addr_valid == 0, "t6_fill_valid", fetch_addr_valid, 0);
        check(fetch_addr == 0, "t6_fetch_addr", fetch_addr, 0);
        check(fetched_data == 0, "t6_data", fetched_data, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        inject_stray = 1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check(inject_stray == 0, "t6_stray_sent", inject_stray, 0);
        check(refill_busy == 0, "t6_stray_idle", refill_busy, 0);
        check(n_fill == nf0, "t6_no_fill", n_fill - nf0, 0);
        queues_empty("t6");

        // Random traffic: misses, ignored misses, backpressure, gaps, stalls.
        beat_gap = 0;
        rand_gap = 1;
        rand_rdy = 1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            ext_stall = ($urandom % 4 == 0);
            miss = 2'b00;
            m = 2'($urandom_range(1, 3));
            if (!refill_busy && $urandom % 3 == 0) begin
                a0 = 32'h4000 + 4 * $urandom_range(0, 63);
                if ($urandom % 2 == 0) a1 = (a0 & ~OFF) + 4 * $urandom_range(0, LS - 1);
                else a1 = 32'h4000 + 4 * $urandom_range(0, 63);
                model_push(m, a0, a1, 1, 1);
                miss = m;
                miss_addr[0] = a0;
                miss_addr[1] = a1;
            end else if (refill_busy && $urandom % 8 == 0) begin
                miss = m;
                miss_addr[0] = 32'h9000 + 4 * $urandom_range(0, 63);
                miss_addr[1] = 32'hA000 + 4 * $urandom_range(0, 63);
            end
        end
        @(posedge clk); #1;
        miss = 2'b00;
        ext_stall = 1'b0;
        wait_idle("rand");
        repeat (4) @(posedge clk);
        queues_empty("rand");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
